// File: rtl/fft_mult_pkg.sv
// Shared helpers for the FFT datapath constant multipliers.
// Provides a constant-foldable clog2, the signed saturation limits expressed
// as magnitudes for a W-bit two's-complement result, and the rounding offset
// used before a right shift by FRAC bits.
package fft_mult_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Largest positive magnitude representable in W bits: 2^(W-1)-1.
    function automatic longint unsigned sat_pos_limit(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Largest negative magnitude representable in W bits: 2^(W-1).
    function automatic longint unsigned sat_neg_limit(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // Half an LSB of the shifted result; zero when nothing is shifted out.
    function automatic longint unsigned rnd_offset(input int frac);
        if (frac == 0) begin
            return 64'd0;
        end
        return 64'd1 << (frac - 1);
    endfunction

endpackage

// File: rtl/const_mult_adder_stage.sv
// One registered level of the shift-add tree.
// Sums adjacent operand pairs and registers the results together with the
// sample's valid and sign bits. Everything holds while en_i is low.
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   en_i     advance enable (low while the pipeline is stalled)
//   valid_i  valid bit of the incoming level
//   sign_i   sign of the sample carried alongside the magnitude
//   opnd_i   N_IN packed operands of WIDTH bits
//   valid_o  registered valid bit
//   sign_o   registered sign bit
//   sum_o    N_IN/2 registered pairwise sums
module const_mult_adder_stage #(
    parameter int N_IN  = 2,
    parameter int WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        valid_i,
    input  logic                        sign_i,
    input  logic [N_IN*WIDTH-1:0]       opnd_i,
    output logic                        valid_o,
    output logic                        sign_o,
    output logic [(N_IN/2)*WIDTH-1:0]   sum_o
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*WIDTH-1:0] sum_d;
    logic [N_OUT*WIDTH-1:0] sum_q;
    logic                   valid_q;
    logic                   sign_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sum_d[i*WIDTH +: WIDTH] = opnd_i[(2*i)*WIDTH +: WIDTH]
                                    + opnd_i[(2*i+1)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
        end else if (en_i) begin
            sum_q   <= sum_d;
            valid_q <= valid_i;
            sign_q  <= sign_i;
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = valid_q;
    assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_const_mult.sv
// Pipelined fixed-constant multiplier for FFT twiddle scaling.
// D_out = saturate(sign(D_in) * ((|D_in| * CONST) >> FRAC)), computed in
// sign-magnitude with a registered shift-add tree and a valid/ready handshake
// that stalls the whole pipeline when the consumer is not ready.
// Optional build macro PIPELINED_CONST_MULT_ROUND_EN selects
// round-half-away-from-zero instead of truncation toward zero.
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   D_in       signed input sample
//   in_valid   D_in is valid
//   in_ready   sample is accepted this cycle (combinational)
//   D_out      signed scaled product
//   out_valid  D_out is valid
//   out_ready  consumer accepts D_out
//   sat_out    D_out was clamped, qualified by out_valid
module pipelined_const_mult
    import fft_mult_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] CONST      = 16'h5A82,
    parameter int                    FRAC       = 15
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic signed [DATA_WIDTH-1:0] D_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] D_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         sat_out
);

    localparam int W       = DATA_WIDTH;
    localparam int PW      = 2 * W;
    localparam int MW      = PW + 1;
    localparam int LEVELS  = clog2(W);
    localparam int LATENCY = LEVELS + 2;
    // Leaf count padded to a power of two so every level halves cleanly.
    localparam int N0       = 1 << LEVELS;
    localparam int ROOT_OFF = 2 * N0 - 2;

    localparam logic [MW-1:0] POS_LIM   = MW'(sat_pos_limit(W));
    localparam logic [MW-1:0] NEG_LIM   = MW'(sat_neg_limit(W));
    localparam logic [W-1:0]  POS_CLAMP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  NEG_CLAMP = {1'b1, {(W-1){1'b0}}};

`ifdef PIPELINED_CONST_MULT_ROUND_EN
    localparam logic [MW-1:0] RND_OFF = MW'(rnd_offset(FRAC));
`else
    localparam logic [MW-1:0] RND_OFF = '0;
`endif

    logic stall;
    logic en;

    logic         valid0_q;
    logic         sign0_q;
    logic [W-1:0] mag0_q;

    // All tree levels share one bus: level n starts at entry
    // 2*N0 - 2*(N0>>n), the leaves (level 0) at entry 0, the root last.
    logic [(2*N0-1)*PW-1:0] tree_w;
    logic [LEVELS:0]        valid_w;
    logic [LEVELS:0]        sign_w;

    logic [MW-1:0] prod_r;
    logic [MW-1:0] mag_s;
    logic [W-1:0]  dout_d;
    logic          sat_d;
    logic [W-1:0]  dout_q;
    logic          sat_q;
    logic          out_valid_q;

    assign stall    = out_valid_q && !out_ready;
    assign en       = !stall;
    assign in_ready = en;

    // |-2^(W-1)| wraps to 2^(W-1), which is exactly representable unsigned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid0_q <= 1'b0;
            sign0_q  <= 1'b0;
            mag0_q   <= '0;
        end else if (en) begin
            valid0_q <= in_valid;
            sign0_q  <= D_in[W-1];
            mag0_q   <= D_in[W-1] ? -D_in : D_in;
        end
    end

    assign valid_w[0] = valid0_q;
    assign sign_w[0]  = sign0_q;

    for (genvar k = 0; k < N0; k++) begin : g_leaf
        if (k < W) begin : g_bit
            assign tree_w[k*PW +: PW] = CONST[k] ? (PW'(mag0_q) << k) : '0;
        end else begin : g_pad
            assign tree_w[k*PW +: PW] = '0;
        end
    end

    for (genvar n = 1; n <= LEVELS; n++) begin : g_level
        localparam int N_IN    = N0 >> (n - 1);
        localparam int IN_OFF  = 2 * N0 - 2 * (N0 >> (n - 1));
        localparam int OUT_OFF = 2 * N0 - 2 * (N0 >> n);

        const_mult_adder_stage #(
            .N_IN  (N_IN),
            .WIDTH (PW)
        ) u_stage (
            .clk_i   (CLK),
            .rst_i   (RST),
            .en_i    (en),
            .valid_i (valid_w[n-1]),
            .sign_i  (sign_w[n-1]),
            .opnd_i  (tree_w[IN_OFF*PW +: N_IN*PW]),
            .valid_o (valid_w[n]),
            .sign_o  (sign_w[n]),
            .sum_o   (tree_w[OUT_OFF*PW +: (N_IN/2)*PW])
        );
    end

    // One spare bit absorbs the rounding carry before the limit compare.
    always_comb begin
        prod_r = {1'b0, tree_w[ROOT_OFF*PW +: PW]} + RND_OFF;
        mag_s  = prod_r >> FRAC;
        sat_d  = 1'b0;
        dout_d = '0;
        if (sign_w[LEVELS]) begin
            sat_d  = mag_s > NEG_LIM;
            dout_d = sat_d ? NEG_CLAMP : -mag_s[W-1:0];
        end else begin
            sat_d  = mag_s > POS_LIM;
            dout_d = sat_d ? POS_CLAMP : mag_s[W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            dout_q      <= dout_d;
            sat_q       <= sat_d;
            out_valid_q <= valid_w[LEVELS];
        end
    end

    assign D_out     = dout_q;
    assign sat_out   = sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipelined_const_mult.sv
module tb_pipelined_const_mult;

`ifdef PIPELINED_CONST_MULT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    localparam int NDUT = 4;
    localparam int LAT  = 6;
    localparam logic [15:0] CONSTS [NDUT] = '{16'h5A82, 16'hFFFF, 16'h0000, 16'h8000};

    logic CLK = 1'b0;
    logic RST;
    logic signed [15:0] D_in;
    logic in_valid;
    logic out_ready;
    logic [NDUT-1:0][15:0] dout;
    logic [NDUT-1:0] ov;
    logic [NDUT-1:0] ir;
    logic [NDUT-1:0] sat;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pipelined_const_mult #(
            .DATA_WIDTH (16),
            .CONST      (CONSTS[g]),
            .FRAC       (15)
        ) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .D_in      (D_in),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .D_out     (dout[g]),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .sat_out   (sat[g])
        );
    end

    typedef struct {
        logic [15:0]           d;
        logic [NDUT-1:0][15:0] e;
        logic [NDUT-1:0]       s;
        int                    acc;
        bit                    chk_lat;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int bp_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: exact integer product of the magnitude, scaled, saturated.
    function automatic void model(input logic [15:0] d, input logic [15:0] c,
                                  output logic [15:0] e, output logic s);
        longint unsigned mag, p, m, lim;
        bit neg;
        neg = d[15];
        mag = neg ? (64'd65536 - 64'(d)) : 64'(d);
        p = mag * 64'(c);
        if (RND) p = p + (64'd1 << 14);
        m = p >> 15;
        lim = neg ? 64'd32768 : 64'd32767;
        s = (m > lim);
        if (s) m = lim;
        e = neg ? 16'(64'd65536 - m) : 16'(m);
    endfunction

    task automatic send(input logic [15:0] d, input bit chk_lat,
                        input int ov_idx, input logic [15:0] ov_e, input logic ov_s);
        item_t it;
        logic [15:0] e;
        logic s;
        int n;
        D_in = d;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge CLK);
            if (ir[0] === 1'b1) break;
            n++;
            if (n > 1000) begin
                $display("FAIL accept_timeout: in_ready stuck at %b, required 1", ir[0]);
                failures++;
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "input never accepted");
            end
        end
        it.d = d;
        for (int g = 0; g < NDUT; g++) begin
            model(d, CONSTS[g], e, s);
            it.e[g] = e;
            it.s[g] = s;
        end
        if (ov_idx >= 0) begin
            it.e[ov_idx] = ov_e;
            it.s[ov_idx] = ov_s;
        end
        it.acc = cyc;
        it.chk_lat = chk_lat;
        sb.push_back(it);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge CLK);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d outputs still outstanding, required 0", sb.size());
            failures++;
            sb.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] rand_sample();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'(16'hFFF0 + $urandom_range(0, 15));
            3: return 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    // Consumer side: mode 0 always ready, 1 scripted back-pressure, 2 random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                1: begin
                    if (bp_cnt >= 8 && bp_cnt < 11) out_ready = 1'b0;
                    else if (bp_cnt >= 11) out_ready = 1'($urandom_range(0, 1));
                    else out_ready = 1'b1;
                    bp_cnt++;
                end
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor.
    initial begin
        item_t it;
        logic prev_stall;
        logic [NDUT-1:0][15:0] prev_dout;
        logic [NDUT-1:0] prev_sat;
        prev_stall = 1'b0;
        prev_dout = '0;
        prev_sat = '0;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                for (int g = 1; g < NDUT; g++) begin
                    checks++;
                    if (ov[g] !== ov[0]) begin
                        $display("FAIL valid_agree dut%0d: out_valid %b, required %b", g, ov[g], ov[0]);
                        failures++;
                    end
                end
                checks++;
                if (ir[0] !== !(ov[0] && !out_ready)) begin
                    $display("FAIL in_ready: got %b, required %b", ir[0], !(ov[0] && !out_ready));
                    failures++;
                end
                if (prev_stall) begin
                    checks++;
                    if (ov[0] !== 1'b1 || dout !== prev_dout || sat !== prev_sat) begin
                        $display("FAIL stall_hold: valid %b D_out %h sat %b, required 1 %h %b",
                                 ov[0], dout, sat, prev_dout, prev_sat);
                        failures++;
                    end
                end
                if (ov[0] === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL unexpected_output: D_out %h with nothing outstanding", dout[0]);
                        failures++;
                    end else begin
                        it = sb.pop_front();
                        for (int g = 0; g < NDUT; g++) begin
                            checks++;
                            if (dout[g] !== it.e[g] || sat[g] !== it.s[g]) begin
                                $display("FAIL data dut%0d D_in=%h: D_out %h sat %b, required %h %b",
                                         g, it.d, dout[g], sat[g], it.e[g], it.s[g]);
                                failures++;
                            end
                        end
                        if (it.chk_lat) begin
                            checks++;
                            if (cyc - it.acc != LAT) begin
                                $display("FAIL latency D_in=%h: %0d cycles, required %0d",
                                         it.d, cyc - it.acc, LAT);
                                failures++;
                            end
                        end
                    end
                end
                prev_stall = ov[0] && !out_ready;
                prev_dout = dout;
                prev_sat = sat;
            end
        end
    end

    initial begin
        RST = 1'b1;
        in_valid = 1'b0;
        D_in = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int g = 0; g < NDUT; g++) begin
            checks++;
            if (dout[g] !== 16'h0 || ov[g] !== 1'b0 || sat[g] !== 1'b0) begin
                $display("FAIL reset_state dut%0d: D_out %h valid %b sat %b, required 0000 0 0",
                         g, dout[g], ov[g], sat[g]);
                failures++;
            end
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Directed points with literal expectations and latency checks.
        rdy_mode = 0;
        send(16'h4000, 1, 0, 16'h2D41, 1'b0);
        send(16'hC000, 1, 0, 16'hD2BF, 1'b0);
        send(16'h0001, 1, 0, RND ? 16'h0001 : 16'h0000, 1'b0);
        send(16'hFFFF, 1, 0, RND ? 16'hFFFF : 16'h0000, 1'b0);
        send(16'h7FFF, 1, 1, 16'h7FFF, 1'b1);
        send(16'h8000, 1, 1, 16'h8000, 1'b1);
        send(16'h0100, 1, 1, RND ? 16'h0200 : 16'h01FF, 1'b0);
        send(16'h8000, 1, 3, 16'h8000, 1'b0);
        send(16'h7FFF, 1, 3, 16'h7FFF, 1'b0);
        send(16'h1234, 1, 2, 16'h0000, 1'b0);
        send(16'hB7E5, 1, 3, 16'hB7E5, 1'b0);
        drain();

        // Back-pressure: 20 back-to-back samples, 3-cycle drop at cycle 8.
        bp_cnt = 0;
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) send(rand_sample(), 0, -1, '0, 1'b0);
        drain();
        rdy_mode = 0;
        idle(2);

        // Reset with four samples in flight.
        for (int i = 0; i < 4; i++) send(rand_sample(), 0, -1, '0, 1'b0);
        RST = 1'b1;
        sb.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (ov !== '0) begin
            $display("FAIL reset_flush: out_valid %b, required 0000", ov);
            failures++;
        end
        checks++;
        if (ir[0] !== 1'b1) begin
            $display("FAIL reset_ready: in_ready %b, required 1", ir[0]);
            failures++;
        end
        @(posedge CLK);
        #1;
        send(16'h4000, 1, 0, 16'h2D41, 1'b0);
        drain();
        idle(10);

        // Randomized traffic with gaps and random consumer stalls.
        rdy_mode = 2;
        for (int i = 0; i < 120; i++) begin
            idle($urandom_range(0, 2));
            send(rand_sample(), 0, -1, '0, 1'b0);
        end
        drain();
        rdy_mode = 0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
